// File: rtl/spi_master_seq.sv
// spi_master_seq: host-side SPI transaction sequencer.
// Each request is sent as two slave frames (address, then data). Reads also
// collect ADDR_SIZE bits from MISO. SS_n/MOSI are registered and computed from
// the next state, so they line up with the state the machine is in.
//
// Handshake: a request transfers on a clk edge where req_valid && req_ready.
// req_ready is high only in IDLE. The host may hold req_valid high at any time.
// rsp_valid is a one-cycle pulse marking the end of a transaction.
module spi_master_seq #(
   parameter int ADDR_SIZE = 8,
   parameter int RD_WAIT   = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_rd,
   input  logic [ADDR_SIZE-1:0] req_addr,
   input  logic [ADDR_SIZE-1:0] req_wdata,
   output logic                 rsp_valid,
   output logic [ADDR_SIZE-1:0] rsp_rdata,
   output logic                 busy,
   output logic                 SS_n,
   output logic                 MOSI,
   input  logic                 MISO
);

   localparam int FW = ADDR_SIZE + 2;
   localparam int CW = $clog2(FW + 1);
   localparam logic [CW-1:0] SHIFT_LOAD = CW'(FW - 1);
   localparam logic [CW-1:0] RECV_LOAD  = CW'(ADDR_SIZE - 1);
   localparam logic [3:0]    WAIT_LOAD  = (RD_WAIT > 1) ? 4'(RD_WAIT - 2) : 4'd0;

   typedef enum logic [2:0] {
      S_IDLE, S_SEL, S_CMD, S_SHIFT, S_WAIT, S_RECV, S_GAP
   } state_t;

   state_t                 state, next_state;
   logic                   frame_b;   // 0 = address frame, 1 = data frame
   logic                   op_rd;
   logic [ADDR_SIZE-1:0]   addr_q, wdata_q;
   logic [FW-1:0]          sh;
   logic [CW-1:0]          bit_cnt;
   logic [3:0]             wait_cnt;
   logic [ADDR_SIZE-1:0]   rx_sh;
   logic [ADDR_SIZE-1:0]   rx_nxt;
   logic [ADDR_SIZE-1:0]   payload;
   logic [FW-1:0]          word;
   logic                   mosi_nxt;

   assign req_ready = (state == S_IDLE);
   assign busy      = ~req_ready;
   assign rx_nxt    = {rx_sh[ADDR_SIZE-2:0], MISO};

   // State register; reset aborts any frame immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   // Next-state, current frame word and next MOSI value
   always_comb begin
      next_state = state;
      mosi_nxt   = 1'b0;
      payload    = frame_b ? (op_rd ? '0 : wdata_q) : addr_q;
      word       = {op_rd, frame_b, payload};
      case (state)
         S_IDLE:  if (req_valid) next_state = S_SEL;
         S_SEL:   next_state = S_CMD;
         S_CMD:   next_state = S_SHIFT;
         S_SHIFT: if (bit_cnt == '0) begin
                     if (frame_b && op_rd) next_state = (RD_WAIT == 1) ? S_RECV : S_WAIT;
                     else                  next_state = S_GAP;
                  end
         S_WAIT:  if (wait_cnt == 4'd0) next_state = S_RECV;
         S_RECV:  if (bit_cnt == '0) next_state = S_GAP;
         S_GAP:   next_state = frame_b ? S_IDLE : S_SEL;
         default: next_state = S_IDLE;
      endcase
      if (next_state == S_CMD)        mosi_nxt = op_rd;
      else if (next_state == S_SHIFT) mosi_nxt = (state == S_CMD) ? word[FW-1] : sh[FW-1];
   end

   // Request capture, frame flag, shift register and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_rd    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         frame_b  <= 1'b0;
         sh       <= '0;
         bit_cnt  <= '0;
         wait_cnt <= 4'd0;
         rx_sh    <= '0;
      end else begin
         if (state == S_IDLE && req_valid) begin
            op_rd   <= req_rd;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            frame_b <= 1'b0;
         end else if (state == S_GAP && !frame_b) begin
            frame_b <= 1'b1;
         end

         if (state == S_CMD)        sh <= word << 1;
         else if (state == S_SHIFT) sh <= sh << 1;

         if (state != S_SHIFT && next_state == S_SHIFT)     bit_cnt <= SHIFT_LOAD;
         else if (state != S_RECV && next_state == S_RECV)  bit_cnt <= RECV_LOAD;
         else if ((state == S_SHIFT || state == S_RECV) && bit_cnt != '0)
            bit_cnt <= bit_cnt - 1'b1;

         if (state != S_WAIT && next_state == S_WAIT)       wait_cnt <= WAIT_LOAD;
         else if (state == S_WAIT && wait_cnt != 4'd0)      wait_cnt <= wait_cnt - 4'd1;

         if (state == S_RECV) rx_sh <= rx_nxt;
      end
   end

   // Registered pin outputs and response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         SS_n      <= 1'b1;
         MOSI      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         SS_n      <= (next_state == S_IDLE) || (next_state == S_GAP);
         MOSI      <= mosi_nxt;
         rsp_valid <= (next_state == S_GAP) && frame_b;
         if (state == S_RECV && next_state == S_GAP) rsp_rdata <= rx_nxt;
      end
   end

endmodule
